// File: rtl/bitrev_pkg.sv
// bitrev_pkg: shared types and the round-robin pick function for the arbiter library.
// Holds the output-stage state enum and rr_pick, which returns the first valid
// index after `last`, wrapping modulo `num`, together with a found flag.
package bitrev_pkg;

    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    typedef enum logic {EMPTY, FULL} out_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   last,
                                         input int unsigned        num);
        rr_pick_t    r;
        int unsigned i;
        r = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            i = (32'(last) + k) % num;
            if (k <= num && !r.found && valid[i]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_arbiter_bit_reverse.sv
// bit_reverse: combinational bit-order reversal, dout[k] = din[DATA_WIDTH-1-k].
// Ports: din (word in), dout (reversed word out).
module bit_reverse #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_rev
        assign dout[g] = din[DATA_WIDTH-1-g];
    end

endmodule

// File: rtl/bitrev_arbiter.sv
// bitrev_arbiter: round-robin arbiter feeding one bit-reversal datapath into a single-entry output stage.
// Ports: clk/resetn (async active-low), req_valid/req_data/req_ready per requester,
// out_valid/out_ready/out_data/out_id toward the single consumer.
module bitrev_arbiter
    import bitrev_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]               out_id
);

    out_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, win_word, win_rev;
    logic [ID_W-1:0]       id_q, id_d, last_q, last_d, winner;
    rr_pick_t              pick;
    logic                  found, accept, fire;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(req_valid), IDX_W'(last_q), NUM_REQ);
        // full-width range check rejects any pick beyond this instance's requesters
        found     = pick.found && (32'(pick.idx) < NUM_REQ);
        winner    = pick.idx[ID_W-1:0];
        accept    = state_q == EMPTY || out_ready;
        // gating with resetn keeps req_ready low for the whole reset interval
        fire      = resetn && accept && found;
        req_ready = fire ? NUM_REQ'(1'b1) << winner : '0;
        win_word  = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
    end

    bit_reverse #(.DATA_WIDTH(DATA_WIDTH)) u_rev (
        .din  (win_word),
        .dout (win_rev)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        if (fire) begin
            state_d = FULL;
            data_d  = win_rev;
            id_d    = winner;
            last_d  = winner;
        end else if (accept) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = state_q == FULL;
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_bitrev_arbiter.sv
// tb_bitrev_arbiter: scoreboard bench for bitrev_arbiter with 4 requesters of 32-bit words.
module tb_bitrev_arbiter;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [31:0]  word [4];
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic [1:0]   out_id;

    int           checks = 0;
    int           errors = 0;
    logic [33:0]  sb [$];
    logic         m_valid = 1'b0;
    logic [1:0]   m_last = 2'd3;
    logic [31:0]  m_data = '0;
    logic [1:0]   m_id = '0;

    assign req_data = {word[3], word[2], word[1], word[0]};

    always #5 clk = ~clk;

    bitrev_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rev(input logic [31:0] d);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = d[31-k];
        return r;
    endfunction

    // one cycle: drive at the negedge, check req_ready mid-cycle, check outputs at the next negedge
    task automatic tick(input logic [3:0] v, input logic o_r, output int gid);
        logic [3:0]  er;
        logic [33:0] e;
        int          w;
        req_valid = v;
        out_ready = o_r;
        #1;
        w = -1;
        if (!m_valid || o_r)
            for (int k = 1; k <= 4; k++)
                if (w < 0 && v[(m_last + k) % 4]) w = (m_last + k) % 4;
        er = (w >= 0) ? 4'(1 << w) : 4'b0;
        chk("req_ready", req_ready, er);
        if (w >= 0) begin
            sb.push_back({2'(w), rev(word[w])});
            m_last  = 2'(w);
            m_valid = 1'b1;
        end else if (o_r) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", out_valid, m_valid);
        if (w >= 0) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e      = sb.pop_front();
                m_id   = e[33:32];
                m_data = e[31:0];
            end
        end
        chk("out_data", out_data, m_data);
        chk("out_id", out_id, m_id);
        gid = w;
    endtask

    logic [31:0] pat_in  [3] = '{32'h0000_0001, 32'hF000_0000, 32'hFFFF_FFFF};
    logic [31:0] pat_out [3] = '{32'h8000_0000, 32'h0000_000F, 32'hFFFF_FFFF};
    int          rr_exp  [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        int g;
        for (int i = 0; i < 4; i++) word[i] = $urandom;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_ready", req_ready, 4'b0);
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_id", out_id, 2'd0);
        req_valid = '0;
        resetn = 1'b1;

        word[0] = 32'h1234_5678;
        tick(4'b0001, 1'b1, g);
        chk("single_gid", g, 0);
        chk("single_valid", out_valid, 1'b1);
        chk("single_data", out_data, 32'h1E6A_2C48);

        for (int i = 0; i < 3; i++) begin
            word[2] = pat_in[i];
            tick(4'b0100, 1'b1, g);
            chk("pat_data", out_data, pat_out[i]);
            chk("pat_id", out_id, 2'd2);
        end

        tick(4'b1000, 1'b1, g);
        chk("pre_rr_gid", g, 3);
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) word[j] = $urandom;
            tick(4'b1111, 1'b1, g);
            chk("rr_gid", g, rr_exp[i]);
            chk("rr_nobubble", out_valid, 1'b1);
        end
        tick(4'b0001, 1'b1, g);
        chk("pre_bp_gid", g, 0);

        for (int i = 0; i < 5; i++) begin
            tick(4'b1010, 1'b0, g);
            chk("bp_gid", g, -1);
            chk("bp_hold_data", out_data, rev(word[0]));
        end
        tick(4'b1010, 1'b1, g);
        chk("bp_gid1", g, 1);
        tick(4'b1010, 1'b1, g);
        chk("bp_gid3", g, 3);

        tick(4'b0000, 1'b1, g);
        chk("drain_valid", out_valid, 1'b0);
        chk("drain_data", out_data, rev(word[3]));

        tick(4'b0100, 1'b1, g);
        chk("pre_rst_valid", out_valid, 1'b1);
        req_valid = 4'b1111;
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ready", req_ready, 4'b0);
        chk("mid_rst_data", out_data, 32'h0);
        sb.delete();
        m_valid = 1'b0;
        m_last  = 2'd3;
        m_data  = '0;
        m_id    = '0;
        @(negedge clk);
        resetn = 1'b1;
        tick(4'b1111, 1'b1, g);
        chk("post_rst_gid", g, 0);
        chk("post_rst_id", out_id, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
